// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte-wide TX FIFO feeding a UART serializer.
// Bit timing comes from a fractional-N baud accumulator.
// Frames are sent back-to-back with no idle bit while the FIFO holds data.
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD_RATE  = 1500000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          drop
);

    localparam int ACC_W = $clog2(CLK_FREQ + BAUD_RATE + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [7:0] DMASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             tick;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [7:0]       head;
    logic             push;
    logic             pop;
    logic             empty;

    state_t           state, state_n;
    logic [7:0]       shreg, shreg_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [1:0]       stop_cnt, stop_cnt_n;
    logic             par_bit, par_bit_n;
    logic             tx_reg, tx_n;
    logic             start_frame;

    assign acc_sum  = acc + ACC_W'(BAUD_RATE);
    assign tick     = (acc_sum >= ACC_W'(CLK_FREQ));
    assign wr_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push     = wr_valid && wr_ready;
    assign empty    = (fifo_count == '0);
    assign head     = mem[rd_ptr];
    assign busy     = (state != ST_IDLE) || !empty;
    assign uart_tx  = tx_reg;

    // Free-running fractional baud accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (tick) begin
            acc <= acc_sum - ACC_W'(CLK_FREQ);
        end else begin
            acc <= acc_sum;
        end
    end

    // FIFO storage; stored bytes are pre-masked to DATA_BITS.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data & DMASK;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (wr_valid && !wr_ready) drop <= 1'b1;
        end
    end

    // Serializer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            par_bit  <= 1'b0;
            tx_reg   <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            par_bit  <= par_bit_n;
            tx_reg   <= tx_n;
        end
    end

    // Next-state logic; the frame-load path is shared by IDLE and the last STOP tick.
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        stop_cnt_n  = stop_cnt;
        par_bit_n   = par_bit;
        tx_n        = tx_reg;
        pop         = 1'b0;
        start_frame = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!empty) start_frame = 1'b1;
                    else        tx_n = 1'b1;
                end
                ST_START: begin
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = 4'd1;
                    state_n   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt == 4'(DATA_BITS)) begin
                        if (PARITY != 0) begin
                            tx_n    = par_bit;
                            state_n = ST_PARITY;
                        end else begin
                            tx_n       = 1'b1;
                            stop_cnt_n = 2'd1;
                            state_n    = ST_STOP;
                        end
                    end else begin
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    tx_n       = 1'b1;
                    stop_cnt_n = 2'd1;
                    state_n    = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt == 2'(STOP_BITS)) begin
                        if (!empty) begin
                            start_frame = 1'b1;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end else begin
                        tx_n       = 1'b1;
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_n    = 1'b1;
                    state_n = ST_IDLE;
                end
            endcase
        end
        if (start_frame) begin
            pop       = 1'b1;
            shreg_n   = head;
            par_bit_n = (PARITY == 1) ? ~(^head) : (^head);
            tx_n      = 1'b0;
            state_n   = ST_START;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed checks of several parameterisations of uart_tx_buffered.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       wv  [6];
    logic [7:0] wd  [6];
    logic       tx  [6];
    logic       bsy [6];
    logic       rdy [6];
    logic       drp [6];
    logic [4:0] cnt_a, cnt_b, cnt_c, cnt_e, cnt_f;
    logic [2:0] cnt_d;

    int n_checks = 0;
    int n_fail   = 0;

    // 10-unit clock period.
    always #5 clk = ~clk;

    uart_tx_buffered #(.CLK_FREQ(8), .BAUD_RATE(1)) u_a (
        .clk(clk), .rst(rst), .wr_valid(wv[0]), .wr_data(wd[0]), .wr_ready(rdy[0]),
        .uart_tx(tx[0]), .busy(bsy[0]), .fifo_count(cnt_a), .drop(drp[0]));
    uart_tx_buffered #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2)) u_b (
        .clk(clk), .rst(rst), .wr_valid(wv[1]), .wr_data(wd[1]), .wr_ready(rdy[1]),
        .uart_tx(tx[1]), .busy(bsy[1]), .fifo_count(cnt_b), .drop(drp[1]));
    uart_tx_buffered #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(1)) u_c (
        .clk(clk), .rst(rst), .wr_valid(wv[2]), .wr_data(wd[2]), .wr_ready(rdy[2]),
        .uart_tx(tx[2]), .busy(bsy[2]), .fifo_count(cnt_c), .drop(drp[2]));
    uart_tx_buffered #(.CLK_FREQ(8), .BAUD_RATE(1), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst(rst), .wr_valid(wv[3]), .wr_data(wd[3]), .wr_ready(rdy[3]),
        .uart_tx(tx[3]), .busy(bsy[3]), .fifo_count(cnt_d), .drop(drp[3]));
    uart_tx_buffered u_e (
        .clk(clk), .rst(rst), .wr_valid(wv[4]), .wr_data(wd[4]), .wr_ready(rdy[4]),
        .uart_tx(tx[4]), .busy(bsy[4]), .fifo_count(cnt_e), .drop(drp[4]));
    uart_tx_buffered #(.CLK_FREQ(10), .BAUD_RATE(3)) u_f (
        .clk(clk), .rst(rst), .wr_valid(wv[5]), .wr_data(wd[5]), .wr_ready(rdy[5]),
        .uart_tx(tx[5]), .busy(bsy[5]), .fifo_count(cnt_f), .drop(drp[5]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int get_cnt(input int s);
        case (s)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            2:       return int'(cnt_c);
            3:       return int'(cnt_d);
            4:       return int'(cnt_e);
            default: return int'(cnt_f);
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wv[i] = 1'b0;
            wd[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Steps negedges until the line of instance s is low; n = steps taken (max on timeout).
    task automatic wait_fall(input int s, input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (tx[s] == 1'b0) break;
        end
    endtask

    // Checks every cycle of each line bit, starting at the current negedge.
    task automatic check_bits(input int s, input string tag, input int bits[$], input int period);
        for (int b = 0; b < bits.size(); b++) begin
            logic [31:0] got;
            logic [31:0] exp;
            got = '0;
            exp = '0;
            for (int c = 0; c < period; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                got[c] = tx[s];
                exp[c] = bits[b][0];
            end
            check($sformatf("%s_bit%0d", tag, b), got, exp);
        end
    endtask

    task automatic check_edges(input int s, input string tag, input int first, input int gaps[$]);
        int   n;
        logic prev;
        wait_fall(s, 100, n);
        check({tag, "_first"}, n, first);
        prev = tx[s];
        for (int g = 0; g < gaps.size(); g++) begin
            int m;
            m = 0;
            do begin
                @(negedge clk);
                m++;
            end while (tx[s] == prev && m < 100);
            check($sformatf("%s_gap%0d", tag, g), m, gaps[g]);
            prev = tx[s];
        end
    endtask

    task automatic push_seq(input int s, input int nbytes, input logic [7:0] first, input logic [7:0] step);
        for (int i = 0; i < nbytes; i++) begin
            wv[s] = 1'b1;
            wd[s] = first + 8'(i) * step;
            @(negedge clk);
        end
        wv[s] = 1'b0;
    endtask

    initial begin
        int n;
        int low_seen;
        int fr[$];
        int gp[$];

        // Reset state of every instance.
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wv[i] = 1'b0;
            wd[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 6; s++) begin
            check($sformatf("rst_tx%0d", s),    tx[s],      1);
            check($sformatf("rst_busy%0d", s),  bsy[s],     0);
            check($sformatf("rst_ready%0d", s), rdy[s],     1);
            check($sformatf("rst_drop%0d", s),  drp[s],     0);
            check($sformatf("rst_count%0d", s), get_cnt(s), 0);
        end

        // Single 0xA5 frame, 8N2, 8 cycles per bit.
        do_reset();
        push_seq(0, 1, 8'hA5, 8'h00);
        check("a5_count", cnt_a, 1);
        check("a5_busy", bsy[0], 1);
        wait_fall(0, 40, n);
        check("a5_start_delay", n, 7);
        fr = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
        check_bits(0, "a5", fr, 8);
        @(negedge clk);
        check("a5_busy_end", bsy[0], 0);
        low_seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (tx[0] == 1'b0) low_seen = 1;
        end
        check("a5_idle_line", low_seen, 0);

        // Even parity, 7 data bits; bit 7 of the written byte must be ignored.
        do_reset();
        push_seq(1, 1, 8'h83, 8'h00);
        wait_fall(1, 40, n);
        check("even_start_delay", n, 7);
        fr = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
        check_bits(1, "even", fr, 8);

        // Odd parity variant of the same byte.
        do_reset();
        push_seq(2, 1, 8'h03, 8'h00);
        wait_fall(2, 40, n);
        check("odd_start_delay", n, 7);
        fr = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
        check_bits(2, "odd", fr, 8);

        // Depth-4 FIFO: six back-to-back pushes before the first tick.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wv[3] = 1'b1;
            wd[3] = 8'(8'h11 * (i + 1));
            check($sformatf("full_ready%0d", i), rdy[3], (i < 4) ? 1 : 0);
            @(negedge clk);
        end
        wv[3] = 1'b0;
        check("full_count", cnt_d, 4);
        check("full_drop", drp[3], 1);
        wait_fall(3, 40, n);
        check("full_start_delay", n, 2);
        fr.delete();
        for (int k = 0; k < 4; k++) begin
            int byte_v;
            byte_v = 17 * (k + 1);
            fr.push_back(0);
            for (int j = 0; j < 8; j++) fr.push_back((byte_v >> j) & 1);
            fr.push_back(1);
            fr.push_back(1);
        end
        check_bits(3, "burst", fr, 8);
        @(negedge clk);
        check("burst_busy_end", bsy[3], 0);
        check("burst_count_end", cnt_d, 0);
        check("burst_tx_end", tx[3], 1);
        check("burst_drop_sticky", drp[3], 1);

        // Full FIFO with a push on the pop-tick cycle.
        do_reset();
        push_seq(3, 4, 8'hA1, 8'h01);
        check("popfull_count_before", cnt_d, 4);
        check("popfull_ready_before", rdy[3], 0);
        check("popfull_drop_before", drp[3], 0);
        repeat (3) @(negedge clk);
        wv[3] = 1'b1;
        wd[3] = 8'h99;
        @(negedge clk);
        wv[3] = 1'b0;
        check("popfull_count_after", cnt_d, 3);
        check("popfull_drop_after", drp[3], 1);
        check("popfull_start", tx[3], 0);

        // 24 MHz / 1.5 Mbaud: bit period of exactly 16 cycles.
        do_reset();
        push_seq(4, 1, 8'h55, 8'h00);
        gp = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
        check_edges(4, "div16", 15, gp);

        // 10 / 3: bit periods cycle 3,3,4.
        do_reset();
        push_seq(5, 1, 8'h55, 8'h00);
        gp = '{3, 3, 4, 3, 3, 4, 3, 3, 4};
        check_edges(5, "frac", 3, gp);

        // Reset during data bit 4 with two bytes still queued.
        do_reset();
        push_seq(0, 3, 8'hEF, 8'h23);
        repeat (47) @(negedge clk);
        check("midrst_tx_before", tx[0], 0);
        check("midrst_count_before", cnt_a, 2);
        rst = 1'b1;
        #1;
        check("midrst_tx", tx[0], 1);
        check("midrst_count", cnt_a, 0);
        check("midrst_busy", bsy[0], 0);
        check("midrst_ready", rdy[0], 1);
        @(negedge clk);
        rst = 1'b0;
        low_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx[0] == 1'b0) low_seen = 1;
        end
        check("midrst_no_resume", low_seen, 0);
        check("midrst_busy_after", bsy[0], 0);
        check("midrst_count_after", cnt_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case any wait above misbehaves.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 24000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 1500000, meaning line bit rate in bit/s; must satisfy BAUD_RATE <= CLK_FREQ.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 2, meaning stop bits per frame, 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, meaning TX FIFO entries, a power of two, >= 2.
REQ-007 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port wr_valid  input  1  producer offers wr_data this cycle.
REQ-010 SHALL have port wr_data  input  8  byte to send; bits above DATA_BITS-1 ignored.
REQ-011 SHALL have port wr_ready  output  1  FIFO can accept a byte this cycle.
REQ-012 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-013 SHALL have port busy  output  1  frame in progress or FIFO non-empty.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently stored.
REQ-015 SHALL have port drop  output  1  sticky flag, set when wr_valid is high while wr_ready is low.

Function
REQ-016 SHALL generate a one-cycle baud tick from a free-running fractional accumulator: acc += BAUD_RATE each cycle; when acc + BAUD_RATE >= CLK_FREQ, acc <= acc + BAUD_RATE - CLK_FREQ and tick = 1.
REQ-017 SHALL size the accumulator to hold CLK_FREQ + BAUD_RATE without overflow; long-run tick rate SHALL equal BAUD_RATE exactly.
REQ-018 SHALL accept a write on any cycle where wr_valid && wr_ready; wr_ready = (fifo_count != FIFO_DEPTH), a registered-state function with no combinational path from wr_valid.
REQ-019 SHALL NOT accept a write when full, even if a pop occurs in the same cycle.
REQ-020 SHALL, on a simultaneous push and pop, leave fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; transitions occur only on tick cycles.
REQ-022 On a tick in IDLE with FIFO non-empty: SHALL pop the head into the shifter, drive uart_tx = 0, and enter START; with FIFO empty, SHALL hold uart_tx = 1.
REQ-023 On the next tick from START: SHALL drive data bit 0 (LSB first) and enter DATA; on each DATA tick, SHALL drive the next bit until DATA_BITS bits have been sent.
REQ-024 After the last data bit: if PARITY != 0, SHALL drive the parity bit (even: XOR of data bits; odd: its inverse) in PARITY; then SHALL drive 1 in STOP for STOP_BITS ticks.
REQ-025 At the final STOP tick: SHALL start the next frame directly (pop, uart_tx = 0, enter START) if the FIFO is non-empty, otherwise return to IDLE; no extra idle bit between back-to-back frames.
REQ-026 SHALL hold each line bit for exactly one tick interval; uart_tx SHALL be a register output.
REQ-027 SHALL drive busy = (state != IDLE) || (fifo_count != 0).
REQ-028 SHALL set drop when wr_valid && !wr_ready, hold it until reset, and leave FIFO contents unaffected.

Reset
REQ-029 While rst = 1: SHALL hold uart_tx = 1, state = IDLE, accumulator = 0, FIFO empty (fifo_count = 0, wr_ready = 1), busy = 0, drop = 0.
REQ-030 Reset asserted mid-frame SHALL immediately return uart_tx to 1 and discard both the frame in progress and the FIFO contents; no partial frame resumes.

Verification
REQ-031 CLK_FREQ=8, BAUD_RATE=1, defaults otherwise; write 0xA5 once -> at the next tick the line goes low, then 1,0,1,0,0,1,0,1,1,1, each held 8 cycles; then the line stays high, busy falls.
REQ-032 PARITY=2, DATA_BITS=7; write 0x03 -> frame start, 1100000, parity 0, stop bits; with PARITY=1 the parity bit is 1.
REQ-033 FIFO_DEPTH=4; push 6 bytes back-to-back with the line stalled -> 4 accepted, wr_ready low from the 5th, drop = 1; all 4 frames are transmitted contiguously with no gap.
REQ-034 Full FIFO, push on the same cycle as a pop tick -> the push is rejected, fifo_count goes 4 to 3.
REQ-035 CLK_FREQ=24000000, BAUD_RATE=1500000 -> tick exactly every 16 cycles; CLK_FREQ=10, BAUD_RATE=3 -> 3 ticks every 10 cycles.
REQ-036 Assert rst during data bit 4 of a frame with 2 entries queued -> uart_tx = 1 the same cycle, fifo_count = 0; after release, no output until a new write.
